// File: rtl/dsp_pkg.sv
// Shared types and constants for the DC-removal averaging path.
// Holds the controller state encoding and the fill-counter sizing helper.
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FILL,
        RUN
    } avg_state_t;

    localparam int SAMPLE_W    = 16;
    localparam int AVG_SAMPLES = 128;

    // One extra bit so the counter can hold SAMPLES itself and saturate there.
    function automatic int fill_width(input int samples);
        return $clog2(samples) + 1;
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Delay line that carries each averager enable and its warm tag until the
// matching averager result appears; a flush discards everything in flight.
module lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic in_warm,
    output logic out_valid,
    output logic out_warm
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] warm_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            warm_sr  <= '0;
        end else if (flush) begin
            valid_sr <= '0;
            warm_sr  <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | DEPTH'(in_valid);
            warm_sr  <= (warm_sr << 1) | DEPTH'(in_warm);
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_warm  = warm_sr[DEPTH-1];

endmodule

// File: rtl/avg_ctrl.sv
// Sequencer for the running-average DC-removal stage: clears the averager,
// feeds it samples, tracks its fill level and tags results as warm.
module avg_ctrl
    import dsp_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_W,
    parameter int SAMPLES = AVG_SAMPLES,
    parameter int RES_LAT = 2,
    parameter int CLR_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             avg_clr_o,
    output logic             avg_en_o,
    output logic [WIDTH-1:0] avg_data_o,
    input  logic [WIDTH-1:0] avg_res_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_warm_o,
    output logic             drop_o
);

    localparam int FILL_W = fill_width(SAMPLES);
    localparam int CLR_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SAMPLES);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SAMPLES - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYC - 1);

    avg_state_t        state;
    avg_state_t        state_next;
    logic [CLR_W-1:0]  clr_cnt;
    logic [FILL_W-1:0] fill;
    logic              warm;
    logic              running;
    logic              accept;
    logic              clr;
    logic              tail_valid;
    logic              tail_warm;
    logic              en_q;
    logic [WIDTH-1:0]  data_q;
    logic              m_valid_q;
    logic [WIDTH-1:0]  m_data_q;
    logic              m_warm_q;
    logic              drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving (enable low) outranks restarting (clear), which outranks filling;
    // "running" is also the ready strobe, so a clear-cycle sample counts as dropped.
    always_comb begin
        state_next = state;
        clr        = 1'b0;
        running    = (state == FILL || state == RUN) && enable_i && !clear_i;
        accept     = s_valid_i && running;
        case (state)
            IDLE: begin
                if (enable_i) state_next = CLEAR;
            end
            CLEAR: begin
                clr = 1'b1;
                if (!enable_i)               state_next = IDLE;
                else if (clr_cnt == CLR_LAST) state_next = FILL;
            end
            FILL: begin
                if (!enable_i)                       state_next = IDLE;
                else if (clear_i)                    state_next = CLEAR;
                else if (accept && fill == FILL_LAST) state_next = RUN;
            end
            RUN: begin
                if (!enable_i)    state_next = IDLE;
                else if (clear_i) state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
            fill    <= '0;
            warm    <= 1'b0;
        end else begin
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            if (state != FILL && state != RUN) begin
                fill <= '0;
            end else if (accept && fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
            warm <= (state_next == RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            en_q <= accept;
            if (accept) data_q <= s_data_i;
            if (s_valid_i && !running) begin
                drop_q <= 1'b1;
            end else if (state == IDLE && enable_i) begin
                drop_q <= 1'b0;
            end
        end
    end

    // The warm tag travels with the enable, so each result reports the
    // window state at the moment its own sample went into the averager.
    lat_pipe #(
        .DEPTH(RES_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (!running),
        .in_valid (en_q),
        .in_warm  (warm),
        .out_valid(tail_valid),
        .out_warm (tail_warm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_warm_q  <= 1'b0;
        end else begin
            m_valid_q <= tail_valid && running;
            if (tail_valid && running) begin
                m_data_q <= avg_res_i;
                m_warm_q <= tail_warm;
            end else if (!running) begin
                m_warm_q <= 1'b0;
            end
        end
    end

    assign s_ready_o  = running;
    assign avg_clr_o  = clr;
    assign avg_en_o   = en_q;
    assign avg_data_o = data_q;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign m_warm_o   = m_warm_q;
    assign drop_o     = drop_q;

endmodule

// File: doc/avg_ctrl.md
Name: avg_ctrl

Overview:
- Sequencer for the 128-tap running-average DC-removal stage (enable/clear/ready-tracking controller) that sits between the sample merger and the averager.
- Accepts merged samples on a valid strobe and issues single-cycle enable pulses plus registered data to the averager.
- Clears the averager's history on (re)start and tracks the averager's fill level.
- Tags the averager result with valid/warm flags at the correct pipeline offset, so downstream demodulation ignores the first window of biased output.

Parameters:
- WIDTH, 16: sample width, two's complement.
- SAMPLES, 128: averager window length; must be a power of two, at least 2.
- RES_LAT, 2: cycles from an avg_en_o pulse to the matching valid result on avg_res_i; at least 1.
- CLR_CYC, 1: number of cycles avg_clr_o is held high during clear.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 1 runs the DC-removal path.
- clear_i  in  1  single-cycle request to restart the window.
- s_valid_i  in  1  merged-sample strobe from the merger.
- s_data_i  in  WIDTH  merged sample, signed.
- s_ready_o  out  1  controller accepts samples.
- avg_clr_o  out  1  synchronous clear to the averager's rst.
- avg_en_o  out  1  one-cycle sample enable to the averager.
- avg_data_o  out  WIDTH  sample presented to the averager, signed.
- avg_res_i  in  WIDTH  averager output, signed.
- m_valid_o  out  1  result strobe.
- m_data_o  out  WIDTH  result, registered copy of avg_res_i.
- m_warm_o  out  1  1 once a full window has been accumulated.
- drop_o  out  1  sticky: a sample arrived while not ready.

Behaviour:
Reset:
- While rst=1 the controller goes asynchronously to IDLE.
- All outputs are 0, the fill counter is 0 and the latency pipe is cleared.

FSM states:
- IDLE:
  - s_ready_o=0.
  - enable_i=1 moves the FSM to CLEAR on the next edge.
- CLEAR:
  - avg_clr_o=1 for exactly CLR_CYC cycles; s_ready_o=0.
  - The fill counter and latency pipe are zeroed.
  - After CLR_CYC cycles the FSM moves to FILL.
- FILL:
  - s_ready_o=1.
  - Each accepted sample increments the fill counter.
  - When the counter reaches SAMPLES, the FSM moves to RUN and m_warm_o is set.
- RUN:
  - s_ready_o=1; the counter saturates at SAMPLES.

Transitions out of any state:
- enable_i=0 in any non-IDLE state moves the FSM to IDLE on the next edge.
  - m_warm_o clears.
  - Results still in the pipe are discarded (m_valid_o is gated).
- clear_i=1 in FILL or RUN moves the FSM to CLEAR; m_warm_o clears.
- clear_i has priority over s_valid_i in the same cycle: the sample is not accepted and drop_o is set.
- enable_i=0 has priority over clear_i.

Accept path:
- A sample is accepted when s_valid_i and s_ready_o are both 1.
- On the next edge: avg_data_o<=s_data_i and avg_en_o=1 for one cycle.
- avg_data_o holds its value otherwise.
- Back-to-back samples are accepted every cycle; there is no internal buffering.

Drop handling:
- s_valid_i=1 while s_ready_o=0 sets drop_o.
- drop_o is cleared only by rst or by a CLEAR entry triggered from IDLE.

Result path:
- A RES_LAT-deep shift register carries the avg_en_o bit.
- When its tail is 1: m_valid_o=1 and m_data_o<=avg_res_i, both registered.
- The resulting delay from acceptance to m_valid_o is RES_LAT+1 cycles.
- m_data_o holds its value between strobes.

Warm flag:
- m_warm_o is sampled into the same pipe, so each result carries the warm state that held when its sample was accepted.
- The first result flagged warm is the one for the SAMPLES-th accepted sample.

Arithmetic and widths:
- The fill counter is $clog2(SAMPLES)+1 bits wide and saturates; it never wraps.
- No arithmetic is performed on the data; samples pass through bit-exact.

Decomposition:
- Shared package (dsp_pkg) holds:
  - the state encoding typedef (IDLE, CLEAR, FILL, RUN);
  - the SAMPLE_W=16 and AVG_SAMPLES=128 constants;
  - a function for the fill-counter width.
- One sub-module, lat_pipe: a parameterised RES_LAT-deep valid/warm shift register with synchronous flush.

Test Plan:
1. Reset, then enable_i=1:
   - avg_clr_o is high for 1 cycle, then s_ready_o=1.
   - All outputs were 0 during rst.
2. 130 back-to-back samples of value 0x0100 after enable:
   - avg_en_o pulses 130 times; m_valid_o pulses follow each acceptance by 3 cycles.
   - m_warm_o=0 on results 1–127 and m_warm_o=1 from result 128 on.
   - m_data_o equals the stubbed avg_res_i value.
3. clear_i and s_valid_i in the same cycle during RUN:
   - The sample is not accepted and drop_o=1.
   - avg_clr_o pulses and m_warm_o drops to 0.
   - 128 new samples are needed before m_warm_o=1 again.
4. enable_i drops 1 cycle after an accepted sample:
   - No m_valid_o is emitted for that sample; the FSM reaches IDLE and s_ready_o=0.
   - Re-enable produces a clear pulse and resets drop_o.
5. Samples every 5th cycle:
   - avg_en_o is exactly 1 cycle wide per sample.
   - avg_data_o is stable between pulses.
6. rst asserted mid-FILL at fill count 60, asynchronously (not on a clock edge):
   - Outputs go to 0 immediately.
   - After release and re-enable, the fill count restarts from 0.
